// File: rtl/ifetch_unit.sv
// Instruction fetch front end: walks the PC through imemory, buffers up to two
// fetched words and hands {pc, instr} to decode, with redirect and fault handling.
//
// state | meaning
// RUN   | fetching permitted; misaligned or out-of-range PC moves to FAULT
// FAULT | no new fetches; buffered entries drain; left only by redirect or reset
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_address,
  output logic        imem_read_write,
  output logic [31:0] imem_data_in,
  input  logic [31:0] imem_data_out,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] buf_pc_q    [2];
  logic [31:0] buf_instr_q [2];
  logic        push, deq, pc_ok, tail;

  assign pc_ok = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_WORD);
  assign deq   = id_valid && id_ready;
  // count 0/1/2 maps to head, head+1, head (slot freed by a same-cycle dequeue)
  assign tail  = head_q ^ count_q[0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    head_d     = head_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;
    if (redirect_valid) begin
      state_d    = RUN;
      pc_d       = redirect_pc;
      count_d    = 2'd0;
      fault_pc_d = 32'd0;
    end else begin
      if (state_q == RUN && fetch_enable) begin
        if (!pc_ok) begin
          state_d    = FAULT;
          fault_pc_d = pc_q;
        end else if (count_q < 2'd2 || deq) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      case ({push, deq})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      if (deq) head_d = ~head_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Buffer storage needs no reset: outputs are gated by id_valid.
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      buf_pc_q[tail]    <= pc_q;
      buf_instr_q[tail] <= imem_data_out;
    end
  end

  assign imem_address    = pc_q;
  assign imem_read_write = 1'b0;
  assign imem_data_in    = 32'd0;
  assign id_valid        = (count_q != 2'd0);
  assign id_pc           = id_valid ? buf_pc_q[head_q] : 32'd0;
  assign id_instr        = id_valid ? buf_instr_q[head_q] : 32'd0;
  assign fetch_fault     = (state_q == FAULT);
  assign fault_pc        = fault_pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: vector table, directed corner sequences and random
// stimulus against a queue-based reference model of the fetch buffer.
module tb_ifetch_unit;

  localparam int unsigned IMEM = 4096;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_enable = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b0;

  logic [31:0] imem_address, imem_data_in, imem_data_out, id_pc, id_instr, fault_pc;
  logic        imem_read_write, id_valid, fetch_fault;
  logic [31:0] s_address, s_data_in, s_data_out, s_pc, s_instr, s_fault_pc;
  logic        s_read_write, s_valid, s_fault;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      default: return (a * 32'h0001_0003) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  assign imem_data_out = mem_word(imem_address);
  assign s_data_out    = mem_word(s_address);

  ifetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_address(imem_address), .imem_read_write(imem_read_write),
    .imem_data_in(imem_data_in), .imem_data_out(imem_data_out),
    .fetch_enable(fetch_enable), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .fetch_fault(fetch_fault),
    .fault_pc(fault_pc));

  ifetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(16)) dut_small (
    .clock(clock), .reset_n(reset_n),
    .imem_address(s_address), .imem_read_write(s_read_write),
    .imem_data_in(s_data_in), .imem_data_out(s_data_out),
    .fetch_enable(fetch_enable), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(s_valid),
    .id_pc(s_pc), .id_instr(s_instr), .fetch_fault(s_fault),
    .fault_pc(s_fault_pc));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc = 32'd0;
  bit          m_fault = 1'b0;
  logic [31:0] m_fault_pc = 32'd0;
  bit          m_fpc_known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model with the current inputs, clock the DUT, compare.
  task automatic tick();
    bit deq, push;
    if (!reset_n) begin
      m_q.delete();
      m_pc = 32'd0;
      m_fault = 1'b0;
      m_fault_pc = 32'd0;
      m_fpc_known = 1'b1;
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc;
      m_fault = 1'b0;
      m_fpc_known = 1'b0;
    end else begin
      deq = (m_q.size() != 0) && id_ready;
      push = 1'b0;
      if (fetch_enable && !m_fault) begin
        if ((m_pc % 4 != 0) || (longint'(m_pc) + 4 > longint'(IMEM))) begin
          m_fault = 1'b1;
          m_fault_pc = m_pc;
          m_fpc_known = 1'b1;
        end else if (m_q.size() < 2 || deq) begin
          push = 1'b1;
        end
      end
      if (deq) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clock);
    #1;
    check("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
    check("id_pc", id_pc, (m_q.size() != 0) ? m_q[0].pc : 32'd0);
    check("id_instr", id_instr, (m_q.size() != 0) ? m_q[0].instr : 32'd0);
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    if (m_fpc_known) check("fault_pc", fault_pc, m_fault_pc);
    check("imem_address", imem_address, m_pc);
    check("imem_read_write", 32'(imem_read_write), 32'd0);
    check("imem_data_in", imem_data_in, 32'd0);
  endtask

  typedef struct {
    bit          rst_n;
    bit          ready;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{0, 1, 0, 32'h0, 32'h0};
    vecs[1]  = '{1, 1, 1, 32'h0, 32'h4};
    vecs[2]  = '{1, 1, 1, 32'h4, 32'h8};
    vecs[3]  = '{1, 1, 1, 32'h8, 32'hC};
    vecs[4]  = '{0, 0, 0, 32'h0, 32'h0};
    vecs[5]  = '{1, 0, 1, 32'h0, 32'h4};
    vecs[6]  = '{1, 0, 1, 32'h0, 32'h8};
    vecs[7]  = '{1, 0, 1, 32'h0, 32'h8};
    vecs[8]  = '{1, 0, 1, 32'h0, 32'h8};
    vecs[9]  = '{1, 0, 1, 32'h0, 32'h8};
    vecs[10] = '{1, 0, 1, 32'h0, 32'h8};
    vecs[11] = '{1, 1, 1, 32'h4, 32'hC};
    vecs[12] = '{1, 1, 1, 32'h8, 32'h10};
    vecs[13] = '{1, 1, 1, 32'hC, 32'h14};

    // Startup, streaming and backpressure
    for (int i = 0; i < 14; i++) begin
      reset_n = vecs[i].rst_n;
      id_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(id_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_pc", i), id_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_instr", i), id_instr,
            vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'd0);
      check($sformatf("vec%0d_addr", i), imem_address, vecs[i].exp_addr);
    end

    // Redirect while full with a same-cycle accept
    id_ready = 1'b0;
    repeat (3) tick();
    check("full_before_redirect", 32'(id_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    id_ready = 1'b1;
    tick();
    check("redir_valid_drop", 32'(id_valid), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("redir_target_valid", 32'(id_valid), 32'd1);
    check("redir_target_pc", id_pc, 32'h40);

    // Misaligned redirect faults, a later redirect recovers
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("misalign_fault", 32'(fetch_fault), 32'd1);
    check("misalign_fault_pc", fault_pc, 32'h42);
    check("misalign_no_valid", 32'(id_valid), 32'd0);
    repeat (3) tick();
    check("fault_sticky", 32'(fetch_fault), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    check("fault_cleared", 32'(fetch_fault), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("recover_pc", id_pc, 32'h80);
    check("recover_valid", 32'(id_valid), 32'd1);

    // Run-off the end of a 16-byte memory
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    tick();
    check("small_redir_valid", 32'(s_valid), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("small_pc8", s_pc, 32'h8);
    check("small_instr8", s_instr, mem_word(32'h8));
    tick();
    check("small_pcC", s_pc, 32'hC);
    check("small_validC", 32'(s_valid), 32'd1);
    tick();
    check("small_fault", 32'(s_fault), 32'd1);
    check("small_fault_pc", s_fault_pc, 32'h10);
    check("small_drained", 32'(s_valid), 32'd0);

    // Reset while faulted with two buffered entries
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFF8;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    check("top_fault", 32'(fetch_fault), 32'd1);
    check("top_fault_pc", fault_pc, 32'h1000);
    check("top_buffered", id_pc, 32'hFF8);
    reset_n = 1'b0;
    tick();
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_fault_pc", fault_pc, 32'd0);
    check("rst_addr", imem_address, 32'd0);
    reset_n = 1'b1;
    id_ready = 1'b1;
    tick();
    check("restart_pc", id_pc, 32'd0);
    check("restart_valid", 32'(id_valid), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      fetch_enable = ($urandom_range(0, 7) != 0);
      id_ready = $urandom_range(0, 1) == 1;
      redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0: redirect_pc = 32'($urandom_range(0, 1023)) << 2;
        1: redirect_pc = 32'hFF8;
        2: redirect_pc = 32'hFFC;
        3: redirect_pc = 32'($urandom_range(0, 4095));
        default: redirect_pc = 32'h2000;
      endcase
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
